// File: rtl/ras_ckpt.sv
// Return-address stack with recursion counters and checkpoint/restore.
// The stack is a circular buffer indexed by tos; a full push overwrites the oldest entry.
module ras_ckpt #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 33,
  parameter  int CNT_W  = 2,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push_req,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_req,
  output logic              top_valid,
  output logic [DATA_W-1:0] top_data,
  output logic              overflow,
  output logic [PTR_W-1:0]  ckpt_ptr,
  output logic [PTR_W:0]    ckpt_occ,
  output logic [DATA_W-1:0] ckpt_data,
  output logic [CNT_W-1:0]  ckpt_cnt,
  input  logic              restore_req,
  input  logic [PTR_W-1:0]  restore_ptr,
  input  logic [PTR_W:0]    restore_occ,
  input  logic [DATA_W-1:0] restore_data,
  input  logic [CNT_W-1:0]  restore_cnt
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
  } ent_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic             overflow_q, overflow_d;

  ent_t             top;
  logic [PTR_W-1:0] tos_inc, tos_dec;
  logic             empty;
  logic             merge;

  assign top     = ent_q[tos_q];
  assign tos_inc = tos_q + 1'b1;
  assign tos_dec = tos_q - 1'b1;
  assign empty   = (occ_q == '0);
  // Repeated push of the current return address just bumps the recursion count.
  assign merge   = top.valid && (top.data == push_data) && (top.cnt != CNT_MAX);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    tos_d      = tos_q;
    occ_d      = occ_q;
    overflow_d = 1'b0;

    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      tos_d = '0;
      occ_d = '0;
    end else if (restore_req) begin
      tos_d              = restore_ptr;
      occ_d              = restore_occ;
      ent_d[restore_ptr] = '{valid: (restore_occ != '0), data: restore_data, cnt: restore_cnt};
    end else if (push_req && pop_req) begin
      ent_d[tos_q] = '{valid: 1'b1, data: push_data, cnt: '0};
      if (empty) occ_d = (PTR_W+1)'(1);
    end else if (push_req) begin
      if (merge) begin
        ent_d[tos_q].cnt = top.cnt + 1'b1;
      end else begin
        tos_d          = tos_inc;
        ent_d[tos_inc] = '{valid: 1'b1, data: push_data, cnt: '0};
        // When full, tos_inc lands on the oldest entry, so it is simply overwritten.
        if (occ_q == OCC_FULL) overflow_d = 1'b1;
        else                   occ_d      = occ_q + 1'b1;
      end
    end else if (pop_req && !empty) begin
      if (top.cnt != '0) begin
        ent_d[tos_q].cnt = top.cnt - 1'b1;
      end else begin
        ent_d[tos_q].valid = 1'b0;
        tos_d              = tos_dec;
        occ_d              = occ_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    tos_q      <= tos_d;
    occ_q      <= occ_d;
    overflow_q <= overflow_d;
  end

  assign top_valid = !empty;
  assign top_data  = empty ? '0 : top.data;
  assign overflow  = overflow_q;
  assign ckpt_ptr  = tos_q;
  assign ckpt_occ  = occ_q;
  assign ckpt_data = top_data;
  assign ckpt_cnt  = empty ? '0 : top.cnt;

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt at DEPTH=4, CNT_W=2 with hand-computed expectations.
module tb_ras_ckpt;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 33;
  localparam int CNT_W  = 2;
  localparam int PTR_W  = 2;

  logic              clk = 1'b0;
  logic              reset, flush, push_req, pop_req, restore_req;
  logic [DATA_W-1:0] push_data, restore_data;
  logic [PTR_W-1:0]  restore_ptr;
  logic [PTR_W:0]    restore_occ;
  logic [CNT_W-1:0]  restore_cnt;
  logic              top_valid, overflow;
  logic [DATA_W-1:0] top_data, ckpt_data;
  logic [PTR_W-1:0]  ckpt_ptr;
  logic [PTR_W:0]    ckpt_occ;
  logic [CNT_W-1:0]  ckpt_cnt;

  logic [PTR_W-1:0]  cap_ptr;
  logic [PTR_W:0]    cap_occ;
  logic [DATA_W-1:0] cap_data;
  logic [CNT_W-1:0]  cap_cnt;

  int checks = 0;
  int errors = 0;

  ras_ckpt #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_req(push_req), .push_data(push_data), .pop_req(pop_req),
    .top_valid(top_valid), .top_data(top_data), .overflow(overflow),
    .ckpt_ptr(ckpt_ptr), .ckpt_occ(ckpt_occ), .ckpt_data(ckpt_data), .ckpt_cnt(ckpt_cnt),
    .restore_req(restore_req), .restore_ptr(restore_ptr), .restore_occ(restore_occ),
    .restore_data(restore_data), .restore_cnt(restore_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    reset = 1'b0; flush = 1'b0; push_req = 1'b0; pop_req = 1'b0;
    restore_req = 1'b0; push_data = '0;
  endtask

  task automatic op(input logic ps, input logic [DATA_W-1:0] d, input logic pp);
    push_req = ps; push_data = d; pop_req = pp;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vld"},  64'(top_valid), 64'd0);
    chk({tag, "_data"}, 64'(top_data),  64'd0);
    chk({tag, "_ovf"},  64'(overflow),  64'd0);
    chk({tag, "_ptr"},  64'(ckpt_ptr),  64'd0);
    chk({tag, "_occ"},  64'(ckpt_occ),  64'd0);
    chk({tag, "_cd"},   64'(ckpt_data), 64'd0);
    chk({tag, "_cnt"},  64'(ckpt_cnt),  64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; push_req = 1'b0; pop_req = 1'b0; restore_req = 1'b0;
    push_data = '0; restore_data = '0; restore_ptr = '0; restore_occ = '0; restore_cnt = '0;
    @(posedge clk); #1;
    tick();
    chk_reset_vals("rst");

    // Basic LIFO
    op(1, 33'h100, 0); op(1, 33'h200, 0); op(1, 33'h300, 0);
    chk("lifo_top3", 64'(top_data), 64'h300);
    chk("lifo_occ3", 64'(ckpt_occ), 64'd3);
    chk("lifo_ptr3", 64'(ckpt_ptr), 64'd3);
    op(0, '0, 1);
    chk("lifo_top2", 64'(top_data), 64'h200);
    chk("lifo_occ2", 64'(ckpt_occ), 64'd2);
    op(0, '0, 1); op(0, '0, 1);
    chk("lifo_empty_vld",  64'(top_valid), 64'd0);
    chk("lifo_empty_data", 64'(top_data),  64'd0);
    op(0, '0, 1);
    chk("lifo_xpop_occ", 64'(ckpt_occ), 64'd0);
    chk("lifo_xpop_ptr", 64'(ckpt_ptr), 64'd0);

    // Recursion counter
    do_reset();
    for (int i = 0; i < 4; i++) op(1, 33'h400, 0);
    chk("rec_occ1", 64'(ckpt_occ), 64'd1);
    chk("rec_cnt3", 64'(ckpt_cnt), 64'd3);
    op(1, 33'h400, 0);
    chk("rec_occ2", 64'(ckpt_occ), 64'd2);
    chk("rec_cnt0", 64'(ckpt_cnt), 64'd0);
    op(0, '0, 1);
    chk("rec_pop_top", 64'(top_data), 64'h400);
    chk("rec_pop_cnt", 64'(ckpt_cnt), 64'd3);
    chk("rec_pop_occ", 64'(ckpt_occ), 64'd1);
    op(0, '0, 1);
    chk("rec_pop2_cnt", 64'(ckpt_cnt), 64'd2);
    chk("rec_pop2_occ", 64'(ckpt_occ), 64'd1);
    for (int i = 0; i < 3; i++) op(0, '0, 1);
    chk("rec_empty", 64'(top_valid), 64'd0);

    // Overflow and pointer wrap
    do_reset();
    op(1, 33'h10, 0); op(1, 33'h20, 0); op(1, 33'h30, 0); op(1, 33'h40, 0);
    chk("ovf_full_occ", 64'(ckpt_occ), 64'd4);
    chk("ovf_pre",      64'(overflow), 64'd0);
    op(1, 33'h50, 0);
    chk("ovf_pulse", 64'(overflow), 64'd1);
    chk("ovf_occ",   64'(ckpt_occ), 64'd4);
    chk("ovf_ptr",   64'(ckpt_ptr), 64'd1);
    chk("ovf_top",   64'(top_data), 64'h50);
    op(0, '0, 1);
    chk("ovf_clear", 64'(overflow), 64'd0);
    chk("ovf_pop1",  64'(top_data), 64'h40);
    op(0, '0, 1);
    chk("ovf_pop2",  64'(top_data), 64'h30);
    op(0, '0, 1);
    chk("ovf_pop3",  64'(top_data), 64'h20);
    op(0, '0, 1);
    chk("ovf_pop4_vld", 64'(top_valid), 64'd0);

    // Simultaneous push+pop
    do_reset();
    op(1, 33'h10, 0); op(1, 33'h20, 0);
    op(1, 33'h99, 1);
    chk("pp_top", 64'(top_data), 64'h99);
    chk("pp_occ", 64'(ckpt_occ), 64'd2);
    op(0, '0, 1);
    chk("pp_pop", 64'(top_data), 64'h10);
    do_reset();
    op(1, 33'h77, 1);
    chk("pp_empty_occ", 64'(ckpt_occ), 64'd1);
    chk("pp_empty_top", 64'(top_data), 64'h77);

    // Checkpoint / restore
    do_reset();
    op(1, 33'hA, 0); op(1, 33'hB, 0);
    cap_ptr = ckpt_ptr; cap_occ = ckpt_occ; cap_data = ckpt_data; cap_cnt = ckpt_cnt;
    chk("ck_ptr",  64'(cap_ptr),  64'd2);
    chk("ck_occ",  64'(cap_occ),  64'd2);
    chk("ck_data", 64'(cap_data), 64'hB);
    chk("ck_cnt",  64'(cap_cnt),  64'd0);
    op(1, 33'hC, 0); op(0, '0, 1); op(0, '0, 1); op(1, 33'hD, 0);
    chk("ck_pre_top", 64'(top_data), 64'hD);
    chk("ck_pre_occ", 64'(ckpt_occ), 64'd2);
    restore_ptr = cap_ptr; restore_occ = cap_occ; restore_data = cap_data; restore_cnt = cap_cnt;
    restore_req = 1'b1; push_req = 1'b1; push_data = 33'hEE;
    tick();
    chk("rs_top", 64'(top_data), 64'hB);
    chk("rs_occ", 64'(ckpt_occ), 64'd2);
    chk("rs_ptr", 64'(ckpt_ptr), 64'd2);
    op(0, '0, 1);
    chk("rs_pop", 64'(top_data), 64'hA);
    chk("rs_pop_occ", 64'(ckpt_occ), 64'd1);

    // Flush beats restore and push
    op(1, 33'h123, 0);
    flush = 1'b1; restore_req = 1'b1; push_req = 1'b1; push_data = 33'h55;
    restore_ptr = 2'd3; restore_occ = 3'd3; restore_data = 33'h66; restore_cnt = 2'd1;
    tick();
    chk_reset_vals("flush");

    // Reset mid-sequence beats a push
    op(1, 33'h1, 0); op(1, 33'h2, 0);
    reset = 1'b1; push_req = 1'b1; push_data = 33'h3;
    tick();
    chk("mrst_occ", 64'(ckpt_occ),  64'd0);
    chk("mrst_vld", 64'(top_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
